// File: rtl/cmac_acc_unload.sv
// cmac_acc_unload: tags cmac accumulation results with their baseline index,
// buffers them in a show-ahead FIFO and hands them downstream on valid/ready.
// Flags dropped results (sticky overflow) and syncs that cut a window short.
module cmac_acc_unload #(
  parameter int ACC_WIDTH       = 16,
  parameter int BL_BITS         = 3,
  parameter int FIFO_DEPTH_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sync,
  input  logic [2*ACC_WIDTH-1:0]     acc_in,
  input  logic                       acc_valid,
  output logic [2*ACC_WIDTH-1:0]     dout,
  output logic [BL_BITS-1:0]         dout_bl,
  output logic                       dout_last,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [FIFO_DEPTH_BITS:0]   fifo_level,
  output logic                       overflow,
  output logic                       window_err
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

  typedef struct packed {
    logic [2*ACC_WIDTH-1:0] data;
    logic [BL_BITS-1:0]     bl;
    logic                   last;
  } entry_t;

  entry_t                     mem_q [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   level_q, level_d;
  logic [BL_BITS-1:0]         bl_ctr_q, bl_ctr_d;
  logic                       overflow_q, overflow_d;
  logic                       werr_q, werr_d;

  logic                       full, pop, push;
  logic [BL_BITS-1:0]         idx;
  entry_t                     wr_entry, head;

  // Index assignment, FIFO handshake and next-state for all control flops.
  // A dropped sample still advances the baseline counter so indices track
  // cmac output order rather than what actually landed in the FIFO.
  always_comb begin
    full       = (level_q == (FIFO_DEPTH_BITS+1)'(DEPTH));
    pop        = (level_q != '0) & dout_ready;
    push       = acc_valid & (~full | pop);
    idx        = sync ? '0 : bl_ctr_q;
    wr_entry   = '{data: acc_in, bl: idx, last: (idx == '1)};

    bl_ctr_d   = bl_ctr_q;
    if (sync)           bl_ctr_d = acc_valid ? BL_BITS'(1) : '0;
    else if (acc_valid) bl_ctr_d = bl_ctr_q + BL_BITS'(1);

    werr_d     = sync & (bl_ctr_q != '0);
    overflow_d = overflow_q | (acc_valid & full & ~pop);

    wr_ptr_d   = push ? wr_ptr_q + FIFO_DEPTH_BITS'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + FIFO_DEPTH_BITS'(1) : rd_ptr_q;

    level_d    = level_q;
    if (push & ~pop)      level_d = level_q + (FIFO_DEPTH_BITS+1)'(1);
    else if (pop & ~push) level_d = level_q - (FIFO_DEPTH_BITS+1)'(1);
  end

  // Control state; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      bl_ctr_q   <= '0;
      overflow_q <= 1'b0;
      werr_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      bl_ctr_q   <= bl_ctr_d;
      overflow_q <= overflow_d;
      werr_q     <= werr_d;
    end
  end

  // FIFO storage; contents are only meaningful under level_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Show-ahead head; masked to zero while empty so reset clears it at once.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    dout_valid = (level_q != '0);
    dout       = dout_valid ? head.data : '0;
    dout_bl    = dout_valid ? head.bl   : '0;
    dout_last  = dout_valid & head.last;
    fifo_level = level_q;
    overflow   = overflow_q;
    window_err = werr_q;
  end

endmodule

// File: tb/tb_cmac_acc_unload.sv
// Scoreboard bench for cmac_acc_unload: stimulus pushes expected entries,
// a negedge monitor pops and compares whenever the DUT hands one over.
module tb_cmac_acc_unload;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sync = 1'b0;
  logic [31:0] acc_in = '0;
  logic        acc_valid = 1'b0;
  logic [31:0] dout;
  logic [2:0]  dout_bl;
  logic        dout_last;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        window_err;

  cmac_acc_unload #(.ACC_WIDTH(16), .BL_BITS(3), .FIFO_DEPTH_BITS(4)) dut (
    .clk(clk), .rst(rst), .sync(sync), .acc_in(acc_in), .acc_valid(acc_valid),
    .dout(dout), .dout_bl(dout_bl), .dout_last(dout_last), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .fifo_level(fifo_level), .overflow(overflow),
    .window_err(window_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] exp_q[$];

  // model state
  int   mlvl = 0;
  int   mbl  = 0;
  logic movf = 1'b0;
  logic mwerr = 1'b0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: check state left by the previous edge, then drive inputs
  // and advance the model for the upcoming edge.
  task automatic cyc(input logic s, input logic v, input logic [31:0] d, input logic r);
    logic mpop, mpush;
    logic [2:0] idx;
    @(posedge clk); #1;
    chk("level", 36'(fifo_level), 36'(mlvl));
    chk("dout_valid", 36'(dout_valid), 36'(mlvl != 0));
    chk("overflow", 36'(overflow), 36'(movf));
    chk("window_err", 36'(window_err), 36'(mwerr));
    sync = s; acc_valid = v; acc_in = d; dout_ready = r;
    idx   = s ? 3'd0 : 3'(mbl);
    mwerr = s && (mbl != 0);
    mpop  = (mlvl != 0) && r;
    mpush = v && ((mlvl < 16) || mpop);
    if (mpush) exp_q.push_back({d, idx, idx == 3'd7});
    if (v && mlvl == 16 && !mpop) movf = 1'b1;
    mlvl = mlvl + int'(mpush) - int'(mpop);
    if (s) mbl = v ? 1 : 0;
    else if (v) mbl = (mbl + 1) % 8;
  endtask

  function automatic logic [31:0] kv(input int k);
    logic [15:0] re, im;
    re = 16'(k);
    im = 16'(-k);
    return {re, im};
  endfunction

  // Monitor: every accepted head entry must match the scoreboard front.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL pop_empty_sb: got %h/%0d/%0d want none", dout, dout_bl, dout_last);
      end else begin
        chk("pop_entry", {dout, dout_bl, dout_last}, exp_q.pop_front());
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && mlvl != 0; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_valid", 36'(dout_valid), 36'd0);
    chk("rst_level", 36'(fifo_level), 36'd0);
    chk("rst_dout", {dout, dout_bl, dout_last}, 36'd0);
    chk("rst_ovf", 36'(overflow), 36'd0);
    @(negedge clk); rst = 1'b0;

    // streaming window with ready held high
    cyc(1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, kv(k), 1'b1);
    drain();

    // full FIFO with simultaneous pop+push: accepted, no overflow
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1, kv(100 + k), 1'b0);
    cyc(1'b0, 1'b1, kv(200), 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("full_pop_push_lvl", 36'(fifo_level), 36'd16);
    drain();

    // 20 writes into depth 16 with ready low: last 4 dropped
    cyc(1'b1, 1'b1, kv(300), 1'b0);
    for (int k = 1; k < 20; k++) cyc(1'b0, 1'b1, kv(300 + k), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("ovf_sticky", 36'(overflow), 36'd1);
    drain();

    // partial window: sync after 5 results, then sync with valid
    cyc(1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, kv(400 + k), 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, kv(410), 1'b1);
    cyc(1'b1, 1'b1, kv(411), 1'b1);
    cyc(1'b0, 1'b1, kv(412), 1'b1);
    drain();

    // async reset mid-stream with level 6 and bl_ctr 3
    cyc(1'b1, 1'b1, kv(500), 1'b1);
    for (int k = 1; k < 6; k++) cyc(1'b0, 1'b1, kv(500 + k), 1'b1);
    for (int k = 6; k < 11; k++) cyc(1'b0, 1'b1, kv(500 + k), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("pre_rst_level", 36'(fifo_level), 36'd6);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_level", 36'(fifo_level), 36'd0);
    chk("async_rst_valid", 36'(dout_valid), 36'd0);
    chk("async_rst_dout", {dout, dout_bl, dout_last}, 36'd0);
    chk("async_rst_ovf", 36'(overflow), 36'd0);
    exp_q.delete();
    mlvl = 0; mbl = 0; movf = 1'b0; mwerr = 1'b0;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, kv(600 + k), 1'b1);
    drain();

    // random valid/ready with sync aligned to every 8th result
    begin
      int wcnt = 0;
      for (int c = 0; c < 1000; c++) begin
        logic v, r;
        v = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        cyc(v && (wcnt % 8 == 0), v, $urandom, r);
        if (v) wcnt++;
      end
    end
    drain();
    chk("sb_empty", 36'(exp_q.size()), 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
